// File: rtl/vx_commit_gather.sv
`default_nettype none
// ============================================================================
// Module      : vx_commit_gather
// Description : Merges NUM_UNITS execute-unit commit streams into a single
//               writeback/commit stream. Every input owns a 2-entry elastic
//               buffer; a round-robin arbiter with multi-packet (sop/eop)
//               locking picks a buffer head and loads a one-deep registered
//               output stage. Also keeps a retired-thread counter and
//               per-unit input stall counters.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               in_valid/in_data - per-unit packet streams (unit i at slice
//               in_ready           [i*PKTW +: PKTW])
//               out_valid/out_data/out_unit/out_ready - merged stream and
//                                  its source unit
//               commit_count     - sum of popcount(tmask) of eop packets sent
//               perf_stalls      - per-unit cycles with in_valid & ~in_ready
// Revision    : 1.0 - initial release
// ============================================================================
module vx_commit_gather #(
    parameter int NUM_UNITS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 6,
    parameter int PC_BITS     = 32,
    parameter int UUID_W      = 44,
    parameter int WIS_W       = 2,
    parameter int CTR_W       = 44,
    localparam int c_PKTW     = UUID_W + WIS_W + NUM_THREADS + PC_BITS + 1
                                + NR_BITS + NUM_THREADS * XLEN + 2,
    localparam int c_UW       = $clog2(NUM_UNITS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_UNITS-1:0]         in_valid,
    input  logic [NUM_UNITS*c_PKTW-1:0]  in_data,
    output logic [NUM_UNITS-1:0]         in_ready,
    output logic                         out_valid,
    output logic [c_PKTW-1:0]            out_data,
    output logic [c_UW-1:0]              out_unit,
    input  logic                         out_ready,
    output logic [CTR_W-1:0]             commit_count,
    output logic [NUM_UNITS*CTR_W-1:0]   perf_stalls
);

    // LSB position of the tmask field inside a packet
    localparam int c_TM_LSB = 2 + NUM_THREADS * XLEN + NR_BITS + 1 + PC_BITS;

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [NUM_UNITS-1:0] w_head_valid;
    logic [NUM_UNITS-1:0] w_push;
    logic [NUM_UNITS-1:0] w_pop;
    logic [c_PKTW-1:0]    w_head_data [NUM_UNITS];

    logic [c_UW-1:0]      r_rr;
    logic [c_UW-1:0]      w_gnt;
    logic [c_UW-1:0]      w_idx;
    logic                 w_any;
    logic                 w_load_en;
    logic                 w_load;
    logic                 w_head_eop;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_UW-1:0]      r_lock_unit;
    logic [c_UW-1:0]      w_lock_unit_nxt;

    logic [CTR_W-1:0]     w_popcnt;

    // ------------------------------------------------------------------
    // Per-unit 2-entry input buffers and stall counters
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_buf
        logic [c_PKTW-1:0] r_mem [2];
        logic              r_wr_ptr;
        logic              r_rd_ptr;
        logic [1:0]        r_count;
        logic [CTR_W-1:0]  r_stall;

        // Ready comes from pre-pop occupancy so it never depends on the
        // arbiter decision (no combinational path from out_ready).
        assign in_ready[gi]     = (r_count != 2'd2) & ~reset;
        assign w_push[gi]       = in_valid[gi] & in_ready[gi];
        assign w_head_valid[gi] = (r_count != 2'd0);
        assign w_head_data[gi]  = r_mem[r_rd_ptr];

        always_ff @(posedge clk) begin
            if (w_push[gi]) begin
                r_mem[r_wr_ptr] <= in_data[gi*c_PKTW +: c_PKTW];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_push[gi]) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop[gi]) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                case ({w_push[gi], w_pop[gi]})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_stall <= '0;
            end else if (in_valid[gi] & ~in_ready[gi]) begin
                r_stall <= r_stall + CTR_W'(1);
            end
        end

        assign perf_stalls[gi*CTR_W +: CTR_W] = r_stall;
    end

    // ------------------------------------------------------------------
    // Arbiter: while locked only the lock owner may win, even when its
    // head is empty; otherwise round-robin starting at r_rr.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        w_idx = '0;
        if (r_state == c_ST_LOCKED) begin
            w_gnt = r_lock_unit;
            w_any = w_head_valid[r_lock_unit];
        end else begin
            // Scan from farthest to nearest so the candidate closest to
            // r_rr is the last (winning) assignment.
            for (int k = NUM_UNITS - 1; k >= 0; k--) begin
                w_idx = c_UW'((int'(r_rr) + k) % NUM_UNITS);
                if (w_head_valid[w_idx]) begin
                    w_gnt = w_idx;
                    w_any = 1'b1;
                end
            end
        end
    end

    assign w_load_en  = ~out_valid | out_ready;
    assign w_load     = w_load_en & w_any;
    assign w_head_eop = w_head_data[w_gnt][0];

    always_comb begin
        w_pop = '0;
        if (w_load) begin
            w_pop[w_gnt] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_lock_unit <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_unit <= w_lock_unit_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_lock_unit_nxt = r_lock_unit;
        if (w_load) begin
            if (w_head_eop) begin
                w_state_nxt = c_ST_IDLE;
            end else begin
                w_state_nxt     = c_ST_LOCKED;
                w_lock_unit_nxt = w_gnt;
            end
        end
    end

    // Pointer only advances at packet boundaries so a multi-packet
    // sequence does not shift fairness mid-flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr <= '0;
        end else if (w_load & w_head_eop) begin
            if (w_gnt == c_UW'(NUM_UNITS - 1)) begin
                r_rr <= '0;
            end else begin
                r_rr <= w_gnt + c_UW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_unit  <= '0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_data  <= w_head_data[w_gnt];
            out_unit  <= w_gnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Retired-thread counter
    // ------------------------------------------------------------------
    always_comb begin
        w_popcnt = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_popcnt = w_popcnt + CTR_W'(out_data[c_TM_LSB + t]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_count <= '0;
        end else if (out_valid & out_ready & out_data[0]) begin
            commit_count <= commit_count + w_popcnt;
        end
    end

endmodule
`default_nettype wire
